pipe_scoreboard: RTL and testbench

- Parametrised hazard scoreboard for the in-order RISC-V pipeline.
- Replaces a fixed 2-stage forwarding unit and adds load-use stall detection. Supports configurable pipeline depth and per-instruction result latency, so it also covers multi-cycle ops.
- Sits at the ID/EX boundary. It tracks in-flight destination registers, drives the ID stall and the EX forwarding-mux selects, and reports occupancy and stall statistics.

---
 rtl/pipe_sb_pkg.sv | 18 +
 rtl/sb_src_match.sv | 36 +++
 rtl/pipe_scoreboard.sv | 114 +++++++++++
 tb/tb_pipe_scoreboard.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_sb_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// The entry fields are sized for the default 32-register, 3-slot configuration.
package pipe_sb_pkg;

  localparam int SB_AW = 5;
  localparam int SB_LW = 2;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] rd;
    logic [SB_LW-1:0] rem;
  } sb_entry_t;

  localparam logic [SB_LW-1:0] FWD_RF   = '0;
  localparam logic [SB_LW-1:0] LAT_ALU  = 2'd1;
  localparam logic [SB_LW-1:0] LAT_LOAD = 2'd2;

endpackage

// File: rtl/sb_src_match.sv
// Priority match of one ID source register against the in-flight slots.
// The youngest (lowest-index) matching slot decides between hazard and forward.
module sb_src_match
  import pipe_sb_pkg::*;
#(
  parameter int AW    = SB_AW,
  parameter int LW    = SB_LW,
  parameter int DEPTH = 3
) (
  input  sb_entry_t        slots_i [DEPTH],
  input  logic [AW-1:0]    rs_i,
  input  logic             use_i,
  output logic             hazard_o,
  output logic [LW-1:0]    fwd_o
);

  always_comb begin
    hazard_o = 1'b0;
    fwd_o    = FWD_RF;
    if (use_i && (rs_i != '0)) begin
      // Walk oldest to youngest so the youngest match overrides the rest.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slots_i[k].valid && (slots_i[k].rd == rs_i)) begin
          if (slots_i[k].rem > LW'(1)) begin
            hazard_o = 1'b1;
            fwd_o    = FWD_RF;
          end else begin
            hazard_o = 1'b0;
            fwd_o    = LW'(k + 1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard scoreboard at the ID/EX boundary: tracks in-flight destinations,
// raises the load-use stall and selects the EX forwarding sources.
module pipe_scoreboard
  import pipe_sb_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int LW    = 2,
  parameter int CW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          issue_valid_i,
  input  logic          issue_we_i,
  input  logic [AW-1:0] issue_rd_i,
  input  logic [LW-1:0] issue_lat_i,
  input  logic          flush_i,
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  input  logic          rs1_use_i,
  input  logic          rs2_use_i,
  output logic          stall_o,
  output logic [LW-1:0] fwd1_o,
  output logic [LW-1:0] fwd2_o,
  output logic [LW-1:0] inflight_o,
  output logic [CW-1:0] stall_cnt_o
);

  function automatic logic [LW-1:0] clamp_lat(input logic [LW-1:0] lat);
    if (lat == '0)
      return LAT_ALU;
    else if (int'(lat) > DEPTH)
      return LW'(DEPTH);
    else
      return lat;
  endfunction

  function automatic logic [LW-1:0] sat_dec(input logic [LW-1:0] rem);
    return (rem == '0) ? '0 : rem - LW'(1);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + CW'(1);
  endfunction

  sb_entry_t     slot_p0 [DEPTH];
  sb_entry_t     slot_d  [DEPTH];
  logic [LW-1:0] inflight_p0;
  logic [LW-1:0] inflight_d;
  logic [CW-1:0] stall_cnt_p0;

  logic          hazard1;
  logic          hazard2;
  logic          rd_tracked;
  logic          issue_ok;

  sb_src_match #(.AW(AW), .LW(LW), .DEPTH(DEPTH)) u_match1 (
    .slots_i  (slot_p0),
    .rs_i     (rs1_i),
    .use_i    (rs1_use_i),
    .hazard_o (hazard1),
    .fwd_o    (fwd1_o)
  );

  sb_src_match #(.AW(AW), .LW(LW), .DEPTH(DEPTH)) u_match2 (
    .slots_i  (slot_p0),
    .rs_i     (rs2_i),
    .use_i    (rs2_use_i),
    .hazard_o (hazard2),
    .fwd_o    (fwd2_o)
  );

  assign stall_o    = issue_valid_i & ~flush_i & (hazard1 | hazard2);
  assign rd_tracked = (issue_rd_i != '0) && (int'(issue_rd_i) < NREG);
  assign issue_ok   = issue_valid_i & issue_we_i & rd_tracked & ~stall_o & ~flush_i;

  // Next slot contents: older slots always advance, slot 0 takes the issue or a bubble.
  always_comb begin
    slot_d[0] = '0;
    if (issue_ok) begin
      slot_d[0].valid = 1'b1;
      slot_d[0].rd    = issue_rd_i;
      slot_d[0].rem   = clamp_lat(issue_lat_i);
    end
    for (int k = 1; k < DEPTH; k++) begin
      slot_d[k]     = slot_p0[k-1];
      slot_d[k].rem = sat_dec(slot_p0[k-1].rem);
    end
    inflight_d = '0;
    for (int k = 0; k < DEPTH; k++)
      inflight_d = inflight_d + LW'(slot_d[k].valid);
  end

  // Stage p0: slot array, occupancy and stall statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++)
        slot_p0[k] <= '0;
      inflight_p0  <= '0;
      stall_cnt_p0 <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++)
        slot_p0[k] <= slot_d[k];
      inflight_p0 <= inflight_d;
      if (stall_o)
        stall_cnt_p0 <= sat_inc(stall_cnt_p0);
    end
  end

  assign inflight_o  = inflight_p0;
  assign stall_cnt_o = stall_cnt_p0;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Randomised and directed bench for pipe_scoreboard against a timestamp-based
// model of in-flight instructions.
module tb_pipe_scoreboard;
  import pipe_sb_pkg::*;

  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int LW    = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          issue_valid_i, issue_we_i, flush_i;
  logic [AW-1:0] issue_rd_i, rs1_i, rs2_i;
  logic [LW-1:0] issue_lat_i;
  logic          rs1_use_i, rs2_use_i;
  logic          stall_o;
  logic [LW-1:0] fwd1_o, fwd2_o, inflight_o;
  logic [CW-1:0] stall_cnt_o;

  pipe_scoreboard #(.NREG(NREG), .AW(AW), .DEPTH(DEPTH), .LW(LW), .CW(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .issue_valid_i (issue_valid_i),
    .issue_we_i    (issue_we_i),
    .issue_rd_i    (issue_rd_i),
    .issue_lat_i   (issue_lat_i),
    .flush_i       (flush_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .rs1_use_i     (rs1_use_i),
    .rs2_use_i     (rs2_use_i),
    .stall_o       (stall_o),
    .fwd1_o        (fwd1_o),
    .fwd2_o        (fwd2_o),
    .inflight_o    (inflight_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Model: each accepted write is remembered with the cycle it issued in.
  typedef struct { int rd; int lat; int cyc; } rec_t;
  rec_t q[$];
  int   now      = 0;
  int   cnt      = 0;
  bit   model_ok = 1'b0;
  bit   exp_stall;
  int   exp_fwd1, exp_fwd2;

  function automatic void src_model(input int rs, input bit use_b, output bit hz, output int fwd);
    int best, lat, age, rem;
    hz = 1'b0; fwd = 0; best = DEPTH; lat = 0;
    if (use_b && rs != 0) begin
      foreach (q[i]) begin
        age = now - q[i].cyc - 1;
        if (age >= 0 && age < DEPTH && q[i].rd == rs && age < best) begin
          best = age; lat = q[i].lat;
        end
      end
      if (best < DEPTH) begin
        rem = lat - best;
        if (rem < 0) rem = 0;
        if (rem > 1) hz = 1'b1;
        else fwd = best + 1;
      end
    end
  endfunction

  function automatic int model_inflight();
    int n = 0;
    foreach (q[i]) if (now - q[i].cyc - 1 >= 0 && now - q[i].cyc - 1 < DEPTH) n++;
    return n;
  endfunction

  task automatic drive(input bit v, input bit we, input int rd, input int lat, input bit fl,
                       input int r1, input bit u1, input int r2, input bit u2);
    issue_valid_i = v;  issue_we_i = we; issue_rd_i = AW'(rd); issue_lat_i = LW'(lat);
    flush_i = fl; rs1_i = AW'(r1); rs1_use_i = u1; rs2_i = AW'(r2); rs2_use_i = u2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic eval();
    bit h1, h2;
    @(negedge clk);
    src_model(int'(rs1_i), rs1_use_i, h1, exp_fwd1);
    src_model(int'(rs2_i), rs2_use_i, h2, exp_fwd2);
    exp_stall = issue_valid_i && !flush_i && (h1 || h2);
    if (model_ok) begin
      chk("stall", stall_o, exp_stall);
      chk("inflight", inflight_o, model_inflight());
      chk("stall_cnt", stall_cnt_o, cnt);
      if (!exp_stall) begin
        chk("fwd1", fwd1_o, exp_fwd1);
        chk("fwd2", fwd2_o, exp_fwd2);
      end
    end
  endtask

  task automatic adv();
    rec_t r;
    if (rst_i) begin
      q.delete(); cnt = 0; model_ok = 1'b1;
    end else begin
      if (exp_stall && cnt < CMAX) cnt++;
      if (issue_valid_i && issue_we_i && issue_rd_i != 0 && !exp_stall && !flush_i) begin
        r.rd  = int'(issue_rd_i);
        r.lat = (issue_lat_i == 0) ? 1 : (int'(issue_lat_i) > DEPTH ? DEPTH : int'(issue_lat_i));
        r.cyc = now;
        q.push_back(r);
      end
    end
    @(posedge clk);
    now++;
    for (int i = q.size() - 1; i >= 0; i--)
      if (now - q[i].cyc - 1 >= DEPTH) q.delete(i);
    #1;
  endtask

  task automatic rand_inputs();
    drive($urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(7, 0),
          $urandom_range(3, 0), ($urandom_range(9, 0) == 0),
          $urandom_range(7, 0), $urandom_range(1, 0),
          $urandom_range(7, 0), $urandom_range(1, 0));
  endtask

  initial begin
    rst_i = 1'b1;
    rand_inputs();
    for (int i = 0; i < 2; i++) begin
      rand_inputs(); eval(); adv();
    end
    rst_i = 1'b0;
    drive(1, 0, 0, 0, 0, 3, 1, 6, 1); eval();
    chk("rst_stall", stall_o, 0);
    chk("rst_fwd1", fwd1_o, 0);
    chk("rst_fwd2", fwd2_o, 0);
    chk("rst_inflight", inflight_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    adv();

    // ALU chain
    drive(1, 1, 5, int'(LAT_ALU), 0, 0, 0, 0, 0); eval(); adv();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); eval();
    chk("alu_stall", stall_o, 0);
    chk("alu_fwd1", fwd1_o, 1);
    adv();
    drive(1, 0, 0, 0, 0, 0, 0, 5, 1); eval();
    chk("alu_fwd2", fwd2_o, 2);
    adv();
    idle(); repeat (3) begin eval(); adv(); end

    // Load-use
    drive(1, 1, 7, int'(LAT_LOAD), 0, 0, 0, 0, 0); eval(); adv();
    drive(1, 0, 0, 0, 0, 0, 0, 7, 1); eval();
    chk("lu_stall", stall_o, 1);
    adv();
    eval();
    chk("lu_stall2", stall_o, 0);
    chk("lu_fwd2", fwd2_o, 2);
    chk("lu_inflight", inflight_o, 1);
    chk("lu_cnt", stall_cnt_o, 1);
    adv();
    idle(); repeat (3) begin eval(); adv(); end

    // Youngest wins, then WB bypass
    drive(1, 1, 3, 1, 0, 0, 0, 0, 0); eval(); adv();
    eval(); adv();
    drive(0, 0, 0, 0, 0, 3, 1, 0, 0); eval();
    chk("young_fwd1", fwd1_o, 1);
    adv();
    eval(); chk("young_fwd1_age1", fwd1_o, 2); adv();
    eval(); chk("wb_bypass", fwd1_o, DEPTH); adv();
    idle(); repeat (3) begin eval(); adv(); end

    // x0 and flush
    drive(1, 1, 0, 1, 0, 0, 1, 0, 0); eval();
    chk("x0_fwd1", fwd1_o, 0);
    adv();
    idle(); eval(); chk("x0_inflight", inflight_o, 0); adv();
    drive(1, 1, 9, 1, 1, 0, 0, 0, 0); eval(); adv();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0); eval();
    chk("flush_fwd1", fwd1_o, 0);
    chk("flush_inflight", inflight_o, 0);
    adv();

    // Reset mid-operation
    drive(1, 1, 4, 2, 0, 0, 0, 0, 0); eval(); adv();
    rst_i = 1'b1; idle(); eval(); adv();
    rst_i = 1'b0;
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0); eval();
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_fwd1", fwd1_o, 0);
    adv();

    // Random traffic with occasional resets; CW is small so the counter saturates.
    for (int i = 0; i < 2000; i++) begin
      rst_i = ($urandom_range(199, 0) == 0);
      rand_inputs();
      eval();
      adv();
    end
    rst_i = 1'b0;
    idle(); eval(); adv();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
